// File: rtl/seg_edit_ctrl.sv
// Single-clock edit/run controller for the six-digit seven-segment counter display.
// Turns key levels into press events, edits a BCD preset buffer, strobes a load, and schedules digit scan with cursor blink.
module seg_edit_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_key,
  input  logic        sel_key,
  input  logic        inc_key,
  input  logic [3:0]  disp_q,
  output logic        edit_mode,
  output logic [2:0]  cur_pos,
  output logic        load_pulse,
  output logic [23:0] load_data,
  output logic [2:0]  scan_pos,
  output logic [5:0]  sel_data,
  output logic [3:0]  seg_bin,
  output logic        blank
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Positions are 1-based; 0 and 7 collapse back to position 1.
  function automatic logic [2:0] pos_next(input logic [2:0] p);
    return (p >= 3'd6 || p == 3'd0) ? 3'd1 : p + 3'd1;
  endfunction

  function automatic logic [2:0] pos_idx(input logic [2:0] p);
    return (p >= 3'd1 && p <= 3'd6) ? p - 3'd1 : 3'd0;
  endfunction

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [5:0] pos_sel_n(input logic [2:0] p);
    logic [5:0] s;
    case (p)
      3'd2:    s = 6'b111101;
      3'd3:    s = 6'b111011;
      3'd4:    s = 6'b110111;
      3'd5:    s = 6'b101111;
      3'd6:    s = 6'b011111;
      default: s = 6'b111110;
    endcase
    return s;
  endfunction

  state_e             state_q, state_d;
  logic [2:0]         cur_pos_q, cur_pos_d;
  logic [23:0]        load_data_q, load_data_d;
  logic               load_pulse_q, load_pulse_d;
  logic               edit_mode_q, edit_mode_d;
  logic [2:0]         scan_pos_q, scan_pos_d;
  logic [5:0]         sel_data_q, sel_data_d;
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_ph_q, blink_ph_d;
  logic               ld_hist_q, sel_hist_q, inc_hist_q;

  logic       ld_ev, sel_ev, inc_ev;
  logic [2:0] edit_idx, scan_idx;

  assign ld_ev    = ~ld_key  & ld_hist_q;
  assign sel_ev   = ~sel_key & sel_hist_q;
  assign inc_ev   = ~inc_key & inc_hist_q;
  assign edit_idx = pos_idx(cur_pos_q);
  assign scan_idx = pos_idx(scan_pos_q);

  always_comb begin
    state_d     = state_q;
    cur_pos_d   = cur_pos_q;
    load_data_d = load_data_q;
    case (state_q)
      ST_RUN: begin
        if (ld_ev) state_d = ST_EDIT;
      end
      ST_EDIT: begin
        // Commit wins; a simultaneous sel/inc is dropped.
        if (ld_ev) begin
          state_d = ST_COMMIT;
        end else begin
          if (inc_ev)
            load_data_d[{edit_idx, 2'b00} +: 4] = bcd_inc(load_data_q[{edit_idx, 2'b00} +: 4]);
          if (sel_ev)
            cur_pos_d = pos_next(cur_pos_q);
        end
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase

    edit_mode_d  = (state_d == ST_EDIT);
    load_pulse_d = (state_d == ST_COMMIT);

    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    scan_pos_d = scan_pos_q;
    if (scan_cnt_q >= SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_pos_d = pos_next(scan_pos_q);
    end
    sel_data_d = pos_sel_n(scan_pos_d);

    // Restart blink visible on every edit entry so the cursor shows immediately.
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    blink_ph_d  = blink_ph_q;
    if (state_q == ST_RUN && state_d == ST_EDIT) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b1;
    end else if (blink_cnt_q >= BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      cur_pos_q    <= 3'd1;
      load_data_q  <= '0;
      load_pulse_q <= 1'b0;
      edit_mode_q  <= 1'b0;
      scan_pos_q   <= 3'd1;
      sel_data_q   <= 6'b111110;
      scan_cnt_q   <= '0;
      blink_cnt_q  <= '0;
      blink_ph_q   <= 1'b1;
      ld_hist_q    <= 1'b1;
      sel_hist_q   <= 1'b1;
      inc_hist_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cur_pos_q    <= cur_pos_d;
      load_data_q  <= load_data_d;
      load_pulse_q <= load_pulse_d;
      edit_mode_q  <= edit_mode_d;
      scan_pos_q   <= scan_pos_d;
      sel_data_q   <= sel_data_d;
      scan_cnt_q   <= scan_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_ph_q   <= blink_ph_d;
      ld_hist_q    <= ld_key;
      sel_hist_q   <= sel_key;
      inc_hist_q   <= inc_key;
    end
  end

  assign edit_mode  = edit_mode_q;
  assign cur_pos    = cur_pos_q;
  assign load_pulse = load_pulse_q;
  assign load_data  = load_data_q;
  assign scan_pos   = scan_pos_q;
  assign sel_data   = sel_data_q;
  assign seg_bin    = (state_q == ST_EDIT) ? load_data_q[{scan_idx, 2'b00} +: 4] : disp_q;
  assign blank      = (state_q == ST_EDIT) && (scan_pos_q == cur_pos_q) && !blink_ph_q;

endmodule
